ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
Sequencer between the PS/2 byte receiver and the CPU I/O bus. It consumes raw scan-code bytes and tracks the E0 (extended) and F0 (release) prefixes with a state machine. Each complete key transition is packed into a 10-bit event word and pushed into a small FIFO. The CPU drains the FIFO through a first-word-fall-through read port and is notified by a level interrupt.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
TIMEOUT_CYCLES, 25000, clk cycles allowed after a prefix byte before the prefix state is abandoned (1 ms at 25 MHz).

Ports:
clk  in  1  system clock (25 MHz domain)
reset  in  1  synchronous, active-high reset
rx_data  in  8  scan-code byte from the PS/2 receiver; valid only while rx_done_tick=1
rx_done_tick  in  1  single-cycle byte-valid strobe; already synchronous to clk
rd_en  in  1  CPU pop request; ignored when empty=1
clr_ovf  in  1  clears the sticky overflow flag
event_data  out  10  FIFO head: [9]=extended, [8]=release, [7:0]=key code
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH)+1  number of stored events
overflow  out  1  sticky flag: an event was dropped because the FIFO was full
irq  out  1  registered copy of !empty

Behaviour:
Reset and clock
- Single clock domain. Reset is synchronous and active-high; it takes priority over every other input.
- Reset values: FSM in IDLE, timer=0, FIFO pointers=0, count=0, empty=1, overflow=0, irq=0, event_data=0.
- Reset asserted mid-sequence (for example after E0 has arrived) discards the partial prefix and all buffered events.

Prefix FSM: states IDLE, EXT, REL, EXT_REL. Bytes are acted on only in cycles where rx_done_tick=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> REL.
  - 00, FF, AA, FA, FE, EE -> discarded, stay in IDLE. These are error, BAT, ACK, resend and echo codes.
  - E1 -> discarded, stay in IDLE. Pause-key sequences are not decoded, so the bytes that follow E1 are processed as ordinary codes.
  - Any other byte -> push {0,0,byte}, stay in IDLE.
- EXT:
  - F0 -> EXT_REL.
  - 12 -> discarded (fake shift), go to IDLE.
  - Any other byte -> push {1,0,byte}, go to IDLE.
- REL:
  - Any byte -> push {0,1,byte}, go to IDLE.
- EXT_REL:
  - 12 -> discarded (fake shift), go to IDLE.
  - Any other byte -> push {1,1,byte}, go to IDLE.
- Prefix timer:
  - Cleared on every accepted byte.
  - Increments each cycle while the FSM is in EXT, REL or EXT_REL.
  - When the timer reaches TIMEOUT_CYCLES-1 with no new byte, the FSM returns to IDLE and nothing is pushed.
  - In IDLE the timer holds at 0.
  - If a byte arrives in the same cycle the timeout would fire, the byte wins.

FIFO
- Latency: an event is pushed in the cycle rx_done_tick carries its final byte. It is visible on event_data with empty=0 on the next cycle. irq follows one cycle after that.
- Read port is first-word-fall-through. event_data always shows the head entry. rd_en=1 with empty=0 pops, and the next entry (or the stale value if the FIFO becomes empty) appears on the following cycle.
- event_data is don't-care while empty=1.
- Pop while empty: no effect; pointers and count do not underflow.
- Push while full with no pop in the same cycle: the event is dropped, overflow is set, and FIFO contents are unchanged.
- Simultaneous push and pop while full: both take effect, count stays at FIFO_DEPTH, and overflow is not set.
- Simultaneous push and pop while empty: the push is stored and the pop is ignored, so count becomes 1.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. count is one bit wider and holds exactly 0..FIFO_DEPTH.

overflow flag
- Cleared by clr_ovf.
- If clr_ovf and a new drop occur in the same cycle, the set wins.

Test Plan:
- Make/break: bytes 1C, then F0 1C -> events 0x01C then 0x11C. count goes 0->1->2 and irq=1. Two rd_en pulses -> empty=1, and irq=0 one cycle later.
- Extended with fake shift: bytes E0 12 E0 75, then E0 F0 75, then E0 F0 12 -> exactly two events: 0x275 (up make) and 0x375 (up break).
- Discard and timeout: bytes AA, then FA, then E0 followed by silence for TIMEOUT_CYCLES, then 1C -> only 0x01C is queued, with extended=0.
- Overflow: 9 make codes with FIFO_DEPTH=8 and no reads -> count=8 and overflow=1. The head is still the first code and the 9th is lost. Pulse clr_ovf -> overflow=0.
- Full with concurrent pop and push: FIFO full, then rd_en and rx_done_tick (byte 29) in the same cycle -> count stays 8, overflow stays 0, and 0x029 is the last entry.
- Mid-sequence reset: E0 received, reset for 1 cycle, then byte 75 -> event 0x075 (not 0x275), with all earlier events flushed.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event controller: decodes E0/F0 scan-code prefixes into 10-bit
// key events, queues them in a first-word-fall-through FIFO and raises a
// level interrupt while events are pending.
module ps2_key_event_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_done_tick,
    input  logic                          i_rd_en,
    input  logic                          i_clr_ovf,
    output logic [9:0]                    o_event_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StRel,
        StExtRel
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic            w_sys_code;
    logic            w_push;
    logic [9:0]      w_push_data;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_irq;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;

    // Flag keyboard housekeeping codes (error, BAT, ACK, resend, echo, pause lead-in).
    always_comb begin
        w_sys_code = 1'b0;
        case (i_rx_data)
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1: w_sys_code = 1'b1;
            default:                                          w_sys_code = 1'b0;
        endcase
    end

    // Prefix FSM next state, prefix timer and event generation.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_push       = 1'b0;
        w_push_data  = 10'h000;
        if (i_rx_done_tick) begin
            // A byte always restarts the prefix timer and beats a same-cycle timeout.
            w_timer_next = '0;
            unique case (r_state)
                StIdle: begin
                    if (i_rx_data == 8'hE0) begin
                        w_state_next = StExt;
                    end else if (i_rx_data == 8'hF0) begin
                        w_state_next = StRel;
                    end else if (!w_sys_code) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b00, i_rx_data};
                    end
                end
                StExt: begin
                    if (i_rx_data == 8'hF0) begin
                        w_state_next = StExtRel;
                    end else begin
                        w_state_next = StIdle;
                        // E0 12 is a fake shift emitted around extended keys.
                        if (i_rx_data != 8'h12) begin
                            w_push      = 1'b1;
                            w_push_data = {2'b10, i_rx_data};
                        end
                    end
                end
                StRel: begin
                    w_state_next = StIdle;
                    w_push       = 1'b1;
                    w_push_data  = {2'b01, i_rx_data};
                end
                StExtRel: begin
                    w_state_next = StIdle;
                    if (i_rx_data != 8'h12) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b11, i_rx_data};
                    end
                end
            endcase
        end else if (r_state != StIdle) begin
            if (r_timer == TIMER_LAST) begin
                w_state_next = StIdle;
                w_timer_next = '0;
            end else begin
                w_timer_next = r_timer + 1'b1;
            end
        end else begin
            w_timer_next = '0;
        end
    end

    // Prefix state and timer registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_pop   = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // FIFO storage, pointers, occupancy, sticky overflow and interrupt.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh drop outranks a same-cycle clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
            r_irq <= !w_empty;
        end
    end

    assign o_event_data = r_mem[r_rd_ptr];
    assign o_empty      = w_empty;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ps2_key_event_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TC    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       rd_en;
    logic       clr_ovf;
    logic [9:0] event_data;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [9:0] m_q[$];
    bit         m_ext;
    bit         m_rel;
    int         m_age;
    bit         m_ovf;
    bit         m_irq;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rx_data),
        .i_rx_done_tick (rx_done_tick),
        .i_rd_en        (rd_en),
        .i_clr_ovf      (clr_ovf),
        .o_event_data   (event_data),
        .o_empty        (empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_irq          (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_sys(input logic [7:0] b);
        return b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};
    endfunction

    // Apply one clock edge worth of inputs to the model.
    task automatic model_edge(input bit rst, input bit vld, input logic [7:0] b,
                              input bit rd, input bit clr);
        bit         pop;
        bit         was_full;
        bit         have_ev;
        bit         drop;
        logic [9:0] ev;
        if (rst) begin
            m_q.delete();
            m_ext = 0;
            m_rel = 0;
            m_age = 0;
            m_ovf = 0;
            m_irq = 0;
            return;
        end
        pop      = rd && (m_q.size() != 0);
        was_full = (m_q.size() == DEPTH);
        have_ev  = 0;
        drop     = 0;
        ev       = '0;
        m_irq    = (m_q.size() != 0);
        if (vld) begin
            if (!m_ext && !m_rel) begin
                if (b == 8'hE0) begin
                    m_ext = 1;
                    m_age = 1;
                end else if (b == 8'hF0) begin
                    m_rel = 1;
                    m_age = 1;
                end else if (!is_sys(b)) begin
                    ev      = {2'b00, b};
                    have_ev = 1;
                end
            end else if (m_ext && !m_rel) begin
                if (b == 8'hF0) begin
                    m_rel = 1;
                    m_age = 1;
                end else begin
                    if (b != 8'h12) begin
                        ev      = {2'b10, b};
                        have_ev = 1;
                    end
                    m_ext = 0;
                end
            end else if (!m_ext && m_rel) begin
                ev      = {2'b01, b};
                have_ev = 1;
                m_rel   = 0;
            end else begin
                if (b != 8'h12) begin
                    ev      = {2'b11, b};
                    have_ev = 1;
                end
                m_ext = 0;
                m_rel = 0;
            end
        end else if (m_ext || m_rel) begin
            // Prefix is honoured for a byte arriving up to TC cycles after it.
            if (m_age == int'(TC)) begin
                m_ext = 0;
                m_rel = 0;
            end else begin
                m_age++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (have_ev) begin
            if (!was_full || pop) m_q.push_back(ev);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check_outputs();
        check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("irq", 32'(irq), 32'(m_irq));
        if (m_q.size() != 0) check_eq("event_data", 32'(event_data), 32'(m_q[0]));
    endtask

    task automatic step(input bit rst, input bit vld, input logic [7:0] b,
                        input bit rd, input bit clr);
        reset        = rst;
        rx_done_tick = vld;
        rx_data      = vld ? b : 8'($urandom_range(0, 255));
        rd_en        = rd;
        clr_ovf      = clr;
        model_edge(rst, vld, b, rd, clr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 1, b, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    task automatic pop_one();
        step(0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        logic [7:0] makes[9];
        logic [7:0] sys_codes[7];
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_done_tick = 1'b0;
        rd_en        = 1'b0;
        clr_ovf      = 1'b0;
        makes        = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        sys_codes    = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};

        // Reset state.
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        check_eq("rst_event_data", 32'(event_data), 32'h000);
        check_eq("rst_empty", 32'(empty), 32'h1);

        // Make/break.
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        idle(1);
        check_eq("mb_count", 32'(count), 32'd2);
        check_eq("mb_head", 32'(event_data), 32'h01C);
        pop_one();
        check_eq("mb_second", 32'(event_data), 32'h11C);
        pop_one();
        idle(2);

        // Extended keys with fake shifts.
        step(1, 0, 8'h00, 0, 0);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h12);
        idle(1);
        check_eq("ext_count", 32'(count), 32'd2);
        check_eq("ext_make", 32'(event_data), 32'h275);
        pop_one();
        check_eq("ext_break", 32'(event_data), 32'h375);
        pop_one();

        // Discards and prefix timeout, plus the last cycle a prefix is still honoured.
        send(8'hAA);
        send(8'hFA);
        send(8'hE0);
        idle(TC);
        send(8'h1C);
        check_eq("to_count", 32'(count), 32'd1);
        check_eq("to_event", 32'(event_data), 32'h01C);
        pop_one();
        send(8'hE0);
        idle(TC - 1);
        send(8'h75);
        check_eq("to_edge_event", 32'(event_data), 32'h275);
        pop_one();
        idle(1);

        // Overflow with nine make codes.
        foreach (makes[i]) send(makes[i]);
        check_eq("ovf_count", 32'(count), 32'd8);
        check_eq("ovf_flag", 32'(overflow), 32'h1);
        check_eq("ovf_head", 32'(event_data), 32'h015);
        step(0, 0, 8'h00, 0, 1);
        check_eq("ovf_clr", 32'(overflow), 32'h0);

        // Full FIFO, concurrent pop and push.
        step(0, 1, 8'h29, 1, 0);
        check_eq("fpp_count", 32'(count), 32'd8);
        check_eq("fpp_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 7; i++) pop_one();
        check_eq("fpp_last", 32'(event_data), 32'h029);
        pop_one();

        // Reset in the middle of a prefix.
        send(8'h1C);
        send(8'hE0);
        step(1, 0, 8'h00, 0, 0);
        send(8'h75);
        check_eq("mid_rst_count", 32'(count), 32'd1);
        check_eq("mid_rst_event", 32'(event_data), 32'h075);
        pop_one();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            int         sel;
            bit         vld;
            bit         rd;
            bit         clr;
            bit         rst;
            logic [7:0] b;
            if ($urandom_range(0, 60) == 0) begin
                idle(int'($urandom_range(TC - 2, TC + 2)));
            end
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3:       b = 8'h12;
                4:       b = sys_codes[$urandom_range(0, 6)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            vld = ($urandom_range(0, 2) != 0);
            rd  = (n < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 400) == 0);
            step(rst, vld, b, rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
